// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the sequencing controller: FSM states, opcodes,
// bus-select codes and instruction field positions.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  // Opcodes live in ir_data[31:28]; 0x1..0x7 are ALU operations passed through as alu_op
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LDI    = 4'h8;
  localparam logic [3:0] OP_LOAD   = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JZ     = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Bus select codes: 1..6 pick r1..r6, all-ones puts the IR on the bus
  localparam logic [2:0] BUS_IDLE = 3'b000;
  localparam logic [2:0] BUS_IR   = 3'b111;

  // Instruction field bit positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int ASEL_MSB = 26;
  localparam int ASEL_LSB = 24;
  localparam int BSEL_MSB = 23;
  localparam int BSEL_LSB = 21;

endpackage

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencing controller: owns the PC, strobes the IR load on
// fetch, decodes the latched instruction into datapath controls and runs
// the data-memory handshake with an optional timeout.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [31:0]     ir_data,
  input  logic            z_flag,
  input  logic            dm_ack,
  output logic [PC_W-1:0] pc,
  output logic            im_r,
  output logic [2:0]      abus_en,
  output logic [2:0]      bbus_en,
  output logic [3:0]      alu_op,
  output logic            reg_we,
  output logic            dm_req,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  // Counter only needs to reach MEM_TIMEOUT-1; a zero timeout disables it
  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam int              TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state;
  state_t          next_state;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  logic [3:0]      opcode;
  logic [2:0]      a_sel;
  logic [2:0]      b_sel;
  logic [PC_W-1:0] target;
  logic            unused_ir;

  assign opcode    = ir_data[OPC_MSB:OPC_LSB];
  assign a_sel     = ir_data[ASEL_MSB:ASEL_LSB];
  assign b_sel     = ir_data[BSEL_MSB:BSEL_LSB];
  assign target    = ir_data[PC_W-1:0];
  assign unused_ir = ^ir_data;

  // Last MEMWAIT cycle without an acknowledge expires the wait
  assign timeout_hit = TO_EN && (state == S_MEMWAIT) && !dm_ack && (to_cnt == TO_LAST);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   next_state = S_DECODE;
      S_DECODE:  next_state = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMWAIT;
          OP_HALT:           next_state = S_HALT;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMWAIT: begin
        if (dm_ack)           next_state = S_FETCH;
        else if (timeout_hit) next_state = S_HALT;
      end
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Moore outputs from state and IR; only LOAD's write enable looks at dm_ack
  always_comb begin
    im_r    = 1'b0;
    abus_en = BUS_IDLE;
    bbus_en = BUS_IDLE;
    alu_op  = 4'h0;
    reg_we  = 1'b0;
    dm_req  = 1'b0;
    busy    = (state != S_IDLE) && (state != S_HALT);
    halted  = (state == S_HALT);
    case (state)
      S_FETCH: im_r = 1'b1;
      S_EXEC: begin
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin
            bbus_en = BUS_IR;
            reg_we  = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            dm_req  = 1'b1;
            abus_en = a_sel;
          end
          default: begin
            if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
              alu_op  = opcode;
              abus_en = a_sel;
              bbus_en = b_sel;
              reg_we  = 1'b1;
            end
          end
        endcase
      end
      S_MEMWAIT: begin
        dm_req  = 1'b1;
        abus_en = a_sel;
        reg_we  = dm_ack && (opcode == OP_LOAD);
      end
      default: ;
    endcase
  end

  // Program counter: increment at end of fetch, redirect on taken jumps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (state == S_FETCH) begin
      pc <= pc + PC_W'(1);
    end else if (state == S_EXEC) begin
      if (opcode == OP_JMP || (opcode == OP_JZ && z_flag)) pc <= target;
    end
  end

  // Counts consecutive MEMWAIT cycles without an acknowledge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          to_cnt <= '0;
    else if (state == S_MEMWAIT && !dm_ack) to_cnt <= to_cnt + TO_W'(1);
    else                                   to_cnt <= '0;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: each instruction pushes its expected
// per-cycle outputs, then the cycles are replayed and compared.
module tb_seq_ctrl;

  localparam int PC_W        = 8;
  localparam int MEM_TIMEOUT = 16;

  logic            clock;
  logic            reset_n;
  logic            start;
  logic [31:0]     ir_data;
  logic            z_flag;
  logic            dm_ack;
  logic [PC_W-1:0] pc;
  logic            im_r;
  logic [2:0]      abus_en;
  logic [2:0]      bbus_en;
  logic [3:0]      alu_op;
  logic            reg_we;
  logic            dm_req;
  logic            busy;
  logic            halted;
  logic            err;

  seq_ctrl #(
    .PC_W       (PC_W),
    .RESET_PC   (8'h00),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .ir_data(ir_data),
    .z_flag (z_flag),
    .dm_ack (dm_ack),
    .pc     (pc),
    .im_r   (im_r),
    .abus_en(abus_en),
    .bbus_en(bbus_en),
    .alu_op (alu_op),
    .reg_we (reg_we),
    .dm_req (dm_req),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  // One cycle of stimulus plus the outputs expected during that cycle
  typedef struct packed {
    logic        start;
    logic        ack;
    logic        z;
    logic [31:0] ir;
    logic [7:0]  pc;
    logic        im_r;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [3:0]  op;
    logic        we;
    logic        req;
    logic        busy;
    logic        halted;
    logic        err;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  model_pc;
  logic        model_err;
  logic [31:0] cur_ir;
  int          cyc;
  int          num_checks;
  int          num_errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic rec_t base_rec();
    rec_t r;
    r       = '0;
    r.start = 1'b1;
    r.ir    = cur_ir;
    r.pc    = model_pc;
    r.err   = model_err;
    return r;
  endfunction

  function automatic rec_t halt_rec(input logic st);
    rec_t r;
    r        = base_rec();
    r.start  = st;
    r.halted = 1'b1;
    return r;
  endfunction

  function automatic rec_t idle_rec(input logic st);
    rec_t r;
    r       = base_rec();
    r.start = st;
    return r;
  endfunction

  task automatic compare_rec(input rec_t r, input string ctx);
    checkOutput({ctx, " pc"},     32'(pc),      32'(r.pc));
    checkOutput({ctx, " im_r"},   32'(im_r),    32'(r.im_r));
    checkOutput({ctx, " abus"},   32'(abus_en), 32'(r.a));
    checkOutput({ctx, " bbus"},   32'(bbus_en), 32'(r.b));
    checkOutput({ctx, " alu_op"}, 32'(alu_op),  32'(r.op));
    checkOutput({ctx, " reg_we"}, 32'(reg_we),  32'(r.we));
    checkOutput({ctx, " dm_req"}, 32'(dm_req),  32'(r.req));
    checkOutput({ctx, " busy"},   32'(busy),    32'(r.busy));
    checkOutput({ctx, " halted"}, 32'(halted),  32'(r.halted));
    checkOutput({ctx, " err"},    32'(err),     32'(r.err));
  endtask

  // Pushes the expected cycles of one instruction starting at its FETCH.
  // ack_at: MEMWAIT cycle carrying dm_ack (0 = never); max_wait stops early (0 = no limit).
  task automatic applyStimulus(input logic [31:0] instr, input logic z, input int ack_at, input int max_wait);
    rec_t       r;
    logic [3:0] opc;
    bit         done;
    opc    = instr[31:28];
    cur_ir = instr;

    r = base_rec(); r.z = z; r.im_r = 1'b1; r.busy = 1'b1;
    exp_q.push_back(r);
    model_pc = model_pc + 8'd1;

    r = base_rec(); r.z = z; r.busy = 1'b1;
    exp_q.push_back(r);

    r = base_rec(); r.z = z; r.busy = 1'b1;
    if (opc >= 4'h1 && opc <= 4'h7) begin
      r.op = opc; r.a = instr[26:24]; r.b = instr[23:21]; r.we = 1'b1;
    end else if (opc == 4'h8) begin
      r.b = 3'b111; r.we = 1'b1;
    end else if (opc == 4'h9 || opc == 4'hA) begin
      r.req = 1'b1; r.a = instr[26:24];
    end
    exp_q.push_back(r);
    if (opc == 4'hB || (opc == 4'hC && z)) model_pc = instr[7:0];

    if (opc == 4'h9 || opc == 4'hA) begin
      done = 1'b0;
      for (int k = 1; k <= MEM_TIMEOUT && !done; k++) begin
        r = base_rec(); r.z = z; r.busy = 1'b1; r.req = 1'b1; r.a = instr[26:24];
        if (k == ack_at) begin
          r.ack = 1'b1; r.we = (opc == 4'h9); done = 1'b1;
        end else if (k == max_wait) begin
          done = 1'b1;
        end
        exp_q.push_back(r);
        if (!done && k == MEM_TIMEOUT) begin
          model_err = 1'b1;
          exp_q.push_back(halt_rec(1'b1));
        end
      end
    end

    if (opc == 4'hF) exp_q.push_back(halt_rec(1'b1));
  endtask

  // Replays queued cycles: drive just after the rising edge, compare on the falling edge
  task automatic play_queue();
    rec_t r;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(posedge clock);
      #1;
      start   = r.start;
      dm_ack  = r.ack;
      z_flag  = r.z;
      ir_data = r.ir;
      @(negedge clock);
      cyc++;
      compare_rec(r, $sformatf("c%0d", cyc));
    end
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives
  task automatic async_reset(input string ctx);
    rec_t r;
    #1;
    reset_n   = 1'b0;
    start     = 1'b0;
    dm_ack    = 1'b0;
    model_pc  = 8'h00;
    model_err = 1'b0;
    #1;
    r = idle_rec(1'b0);
    compare_rec(r, ctx);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    cyc        = 0;
    model_pc   = 8'h00;
    model_err  = 1'b0;
    cur_ir     = 32'h0;
    reset_n    = 1'b0;
    start      = 1'b0;
    ir_data    = 32'h0;
    z_flag     = 1'b0;
    dm_ack     = 1'b0;

    #12;
    compare_rec(idle_rec(1'b0), "reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Idle until start, then ALU ops, LDI and NOP-class opcodes
    exp_q.push_back(idle_rec(1'b0));
    exp_q.push_back(idle_rec(1'b1));
    applyStimulus(32'h1A40_0000, 1'b0, 0, 0);
    applyStimulus(32'h8000_0055, 1'b0, 0, 0);
    applyStimulus(32'h75C0_0000, 1'b0, 0, 0);
    applyStimulus(32'h3F00_0000, 1'b0, 0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0);
    applyStimulus(32'hD123_4567, 1'b0, 0, 0);
    play_queue();

    // Memory handshakes: STORE acked at once, LOAD acked in the fourth wait cycle
    applyStimulus(32'hA300_0000, 1'b0, 1, 0);
    applyStimulus(32'h9200_0000, 1'b0, 4, 0);
    play_queue();

    // Jump near the top of the address space and wrap through 0xFF
    applyStimulus(32'hB000_00FE, 1'b0, 0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0);
    applyStimulus(32'hC000_0010, 1'b0, 0, 0);
    applyStimulus(32'hC000_0040, 1'b1, 0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0, 0);
    play_queue();

    // LOAD never acknowledged: timeout, sticky error, HALT ignoring start
    applyStimulus(32'h9100_0000, 1'b0, 0, 0);
    exp_q.push_back(halt_rec(1'b0));
    exp_q.push_back(halt_rec(1'b1));
    exp_q.push_back(halt_rec(1'b0));
    play_queue();
    async_reset("rst_after_timeout");

    // HALT instruction stays halted with no error
    exp_q.push_back(idle_rec(1'b1));
    applyStimulus(32'hF000_0000, 1'b0, 0, 0);
    exp_q.push_back(halt_rec(1'b0));
    exp_q.push_back(halt_rec(1'b1));
    exp_q.push_back(halt_rec(1'b0));
    play_queue();
    async_reset("rst_after_halt");

    // Reset in the middle of MEMWAIT drops dm_req without a clock edge
    exp_q.push_back(idle_rec(1'b1));
    applyStimulus(32'h9300_0000, 1'b0, 0, 2);
    play_queue();
    async_reset("rst_in_memwait");

    // Controller comes back up from reset and runs again
    exp_q.push_back(idle_rec(1'b1));
    applyStimulus(32'h2FE0_0000, 1'b0, 0, 0);
    play_queue();

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
